mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter INSTRET_EN, default 1; 1 = 64-bit retire counter present, 0 = instret_o tied to 0.
REQ-002 SHALL have clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_ni, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ex_valid_i, input, 1, an instruction is present on the ex_* inputs.
REQ-005 SHALL have the ex_* inputs: regwrite_i (1), rd_addr_i (5), wb_sel_i (2), width_select_i (3, load funct3), memread_i (1), alu_result_i (32), pc_address_i (32), csr_rdata_i (32).
REQ-006 SHALL have dmem_rvalid_i, input, 1, and dmem_rdata_i, input, 32: data-memory load response.
REQ-007 SHALL have stall_o, output, 1, combinational; holds all upstream pipeline registers.
REQ-008 SHALL have the registered outputs wb_valid_o (1), wb_regwrite_o (1), wb_rd_addr_o (5), wb_wdata_o (32), instret_o (64); the wb_* outputs drive the ID-stage register-file write port.

Function
REQ-009 SHALL implement states IDLE and WAIT_LOAD.
REQ-010 IDLE, ex_valid_i=1, memread_i=0: SHALL capture at the next edge and present write-back outputs one cycle after capture.
REQ-011 IDLE, ex_valid_i=1, memread_i=1, dmem_rvalid_i=1: SHALL capture the formatted load data at that edge, with no stall.
REQ-012 IDLE, ex_valid_i=1, memread_i=1, dmem_rvalid_i=0: SHALL latch rd, regwrite, width_select and alu_result_i[1:0] into internal registers, then enter WAIT_LOAD.
REQ-013 stall_o SHALL equal (IDLE & ex_valid_i & memread_i & ~dmem_rvalid_i) | (WAIT_LOAD & ~dmem_rvalid_i).
REQ-014 In WAIT_LOAD, ex_* inputs SHALL be ignored, because upstream holds the same load there.
REQ-015 WAIT_LOAD & dmem_rvalid_i=1: SHALL write back the load at that edge using the latched fields, then return to IDLE.
REQ-016 WAIT_LOAD & dmem_rvalid_i=0: SHALL remain in WAIT_LOAD, with wb_valid_o=0 and wb_regwrite_o=0.
REQ-017 Write-back data selection by wb_sel: 00 = alu_result_i, 01 = formatted load data, 10 = pc_address_i+4 (mod 2^32), 11 = csr_rdata_i.
REQ-018 Load formatting SHALL use byte lane alu_result[1:0] for bytes and bit 1 for halfwords:
- LB (000) / LBU (100): sign-extend / zero-extend the selected byte.
- LH (001) / LHU (101): sign-extend / zero-extend the selected halfword.
- LW (010) and all other codes: full word.
REQ-019 wb_regwrite_o SHALL equal regwrite & (rd != 0); wb_wdata_o is unconstrained when wb_regwrite_o=0.
REQ-020 Bubble (ex_valid_i=0 in IDLE): next-cycle wb_valid_o=0 and wb_regwrite_o=0; wb_rd_addr_o and wb_wdata_o hold.
REQ-021 wb_valid_o SHALL pulse for exactly one cycle per retired instruction, including instructions with regwrite=0.
REQ-022 instret_o SHALL increment by 1 on each edge where a valid instruction is captured, wrap from 2^64-1 to 0, and have no other writer.
REQ-023 dmem_rvalid_i in IDLE with no valid load SHALL be ignored, with no state or output change.
REQ-024 Total latency: 1 cycle from capture to wb_* outputs; loads add (response cycle − issue cycle).

Reset
REQ-025 While rst_ni=0, the block SHALL force state=IDLE and set all registered outputs to 0 immediately, without waiting for a clock edge.
REQ-026 stall_o SHALL be 0 during reset.
REQ-027 Asserting reset in WAIT_LOAD SHALL discard the pending load with no write-back; a response arriving after reset releases SHALL be ignored per REQ-023.
REQ-028 The first capture after reset release SHALL occur no earlier than the first rising edge with rst_ni=1.

Verification
REQ-029 ALU op: ex_valid=1, regwrite=1, rd=5, wb_sel=00, alu_result=0x0000_1234 -> next cycle wb_valid=1, wb_regwrite=1, rd=5, wdata=0x0000_1234, instret=1, stall_o never asserted.
REQ-030 Zero-wait LB: rdata=0x80FF_7F01, addr[1:0]=3, rvalid same cycle -> wdata=0xFFFF_FF80, stall_o=0; same stimulus with LBU -> wdata=0x0000_0080.
REQ-031 Three-cycle-latency LHU: rvalid low for 3 cycles, addr[1:0]=2, rdata=0xBEEF_0000 -> stall_o=1 for exactly 3 cycles, ex inputs ignored while stalled, then wdata=0x0000_BEEF once, instret +1.
REQ-032 Write to x0: rd=0, regwrite=1, JAL with wb_sel=10, pc=0x100 -> wb_valid=1, wb_regwrite=0; the same instruction with rd=1 -> wdata=0x104.
REQ-033 Reset in WAIT_LOAD: pull rst_ni low -> stall_o=0 and all outputs 0 at once; a later rvalid pulse produces no write-back and instret stays 0.
REQ-034 Counter wrap: preload instret to 2^64-1 (via hierarchical force), retire one instruction -> instret=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory/write-back pipeline stage with load-wait FSM and retire counter
//
// Purpose: captures the instruction leaving EX, waits for the data-memory load
// response when needed, formats load data, and drives the register-file write port.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   ex_valid_i           instruction present on ex_* inputs
//   ex_* (*_i)           regwrite, rd_addr, wb_sel, width_select (load funct3),
//                        memread, alu_result, pc_address, csr_rdata
//   dmem_rvalid_i/rdata  data-memory load response
//   stall_o              combinational hold of all upstream pipeline registers
//   wb_*_o               registered write-back (valid, regwrite, rd, wdata)
//   instret_o            64-bit retired-instruction counter (0 when INSTRET_EN=0)
module mem_wb_stage #(
  parameter int INSTRET_EN = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_valid_i,
  input  logic        regwrite_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [2:0]  width_select_i,
  input  logic        memread_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] pc_address_i,
  input  logic [31:0] csr_rdata_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic        wb_regwrite_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_wdata_o,
  output logic [63:0] instret_o
);

  typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

  state_t      state_q, state_d;

  logic        wb_valid_q, wb_valid_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic [63:0] instret_q, instret_d;

  // Fields of a load whose response has not arrived yet
  logic        ld_regwrite_q, ld_regwrite_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_funct3_q, ld_funct3_d;
  logic [1:0]  ld_lane_q, ld_lane_d;

  logic        issue_miss;
  logic        retire;

  function automatic logic [31:0] format_load(input logic [31:0] data,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = lane[1] ? data[31:16] : data[15:0];
    case (funct3)
      3'b000:  format_load = {{24{b[7]}}, b};
      3'b100:  format_load = {24'd0, b};
      3'b001:  format_load = {{16{h[15]}}, h};
      3'b101:  format_load = {16'd0, h};
      default: format_load = data;
    endcase
  endfunction

  // A load issued in IDLE whose response is not in the same cycle
  assign issue_miss = (state_q == IDLE) & ex_valid_i & memread_i & ~dmem_rvalid_i;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (issue_miss) state_d = WAIT_LOAD;
      WAIT_LOAD: if (dmem_rvalid_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM: outputs. Gated with reset so upstream is never held while in reset.
  always_comb begin
    stall_o = 1'b0;
    if (rst_ni) begin
      case (state_q)
        IDLE:      stall_o = issue_miss;
        WAIT_LOAD: stall_o = ~dmem_rvalid_i;
        default:   stall_o = 1'b0;
      endcase
    end
  end

  // Write-back datapath
  always_comb begin
    wb_valid_d    = 1'b0;
    wb_regwrite_d = 1'b0;
    wb_rd_addr_d  = wb_rd_addr_q;
    wb_wdata_d    = wb_wdata_q;
    ld_regwrite_d = ld_regwrite_q;
    ld_rd_d       = ld_rd_q;
    ld_funct3_d   = ld_funct3_q;
    ld_lane_d     = ld_lane_q;
    retire        = 1'b0;

    if (state_q == IDLE) begin
      if (ex_valid_i && !(memread_i && !dmem_rvalid_i)) begin
        retire        = 1'b1;
        wb_valid_d    = 1'b1;
        wb_regwrite_d = regwrite_i & (rd_addr_i != 5'd0);
        wb_rd_addr_d  = rd_addr_i;
        case (wb_sel_i)
          2'b00:   wb_wdata_d = alu_result_i;
          2'b01:   wb_wdata_d = format_load(dmem_rdata_i, width_select_i, alu_result_i[1:0]);
          2'b10:   wb_wdata_d = pc_address_i + 32'd4;
          default: wb_wdata_d = csr_rdata_i;
        endcase
      end else if (issue_miss) begin
        ld_regwrite_d = regwrite_i;
        ld_rd_d       = rd_addr_i;
        ld_funct3_d   = width_select_i;
        ld_lane_d     = alu_result_i[1:0];
      end
    end else if (dmem_rvalid_i) begin
      // ex_* inputs are ignored here: upstream is holding the same load
      retire        = 1'b1;
      wb_valid_d    = 1'b1;
      wb_regwrite_d = ld_regwrite_q & (ld_rd_q != 5'd0);
      wb_rd_addr_d  = ld_rd_q;
      wb_wdata_d    = format_load(dmem_rdata_i, ld_funct3_q, ld_lane_q);
    end

    instret_d = instret_q;
    if (retire && (INSTRET_EN != 0)) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_addr_q  <= 5'd0;
      wb_wdata_q    <= 32'd0;
      instret_q     <= 64'd0;
      ld_regwrite_q <= 1'b0;
      ld_rd_q       <= 5'd0;
      ld_funct3_q   <= 3'd0;
      ld_lane_q     <= 2'd0;
    end else begin
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_addr_q  <= wb_rd_addr_d;
      wb_wdata_q    <= wb_wdata_d;
      instret_q     <= instret_d;
      ld_regwrite_q <= ld_regwrite_d;
      ld_rd_q       <= ld_rd_d;
      ld_funct3_q   <= ld_funct3_d;
      ld_lane_q     <= ld_lane_d;
    end
  end

  assign wb_valid_o    = wb_valid_q;
  assign wb_regwrite_o = wb_regwrite_q;
  assign wb_rd_addr_o  = wb_rd_addr_q;
  assign wb_wdata_o    = wb_wdata_q;
  assign instret_o     = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage with a retirement-level reference model
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        regwrite = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [1:0]  wb_sel = '0;
  logic [2:0]  width_sel = '0;
  logic        memread = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] pc_address = '0;
  logic [31:0] csr_rdata = '0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        stall;
  logic        wb_valid;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic [63:0] instret;

  mem_wb_stage #(.INSTRET_EN(1)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .ex_valid_i    (ex_valid),
    .regwrite_i    (regwrite),
    .rd_addr_i     (rd_addr),
    .wb_sel_i      (wb_sel),
    .width_select_i(width_sel),
    .memread_i     (memread),
    .alu_result_i  (alu_result),
    .pc_address_i  (pc_address),
    .csr_rdata_i   (csr_rdata),
    .dmem_rvalid_i (rvalid),
    .dmem_rdata_i  (rdata),
    .stall_o       (stall),
    .wb_valid_o    (wb_valid),
    .wb_regwrite_o (wb_regwrite),
    .wb_rd_addr_o  (wb_rd),
    .wb_wdata_o    (wb_wdata),
    .instret_o     (instret)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_cnt = 0;

  // Reference model state: expected outputs plus one outstanding load
  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;
  logic [63:0] m_inst;
  logic        m_pend;
  logic        p_rw;
  logic [4:0]  p_rd;
  logic [2:0]  p_f;
  logic [1:0]  p_a;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [2:0] f, input logic [1:0] a);
    logic [31:0] bv, hv;
    int sb, sh;
    sb = 8 * int'(a);
    sh = a[1] ? 16 : 0;
    bv = (d >> sb) & 32'h0000_00FF;
    hv = (d >> sh) & 32'h0000_FFFF;
    if (f == 3'b000) return bv[7] ? (bv | 32'hFFFF_FF00) : bv;
    if (f == 3'b100) return bv;
    if (f == 3'b001) return hv[15] ? (hv | 32'hFFFF_0000) : hv;
    if (f == 3'b101) return hv;
    return d;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_rd = 0; m_wdata = 0; m_inst = 0; m_pend = 0;
  endtask

  task automatic model_retire(input logic rw, input logic [4:0] rd, input logic [31:0] val);
    m_valid = 1;
    m_rw    = rw && (rd != 0);
    m_rd    = rd;
    m_wdata = val;
    m_inst  = m_inst + 1;
  endtask

  task automatic model_edge();
    logic [31:0] v;
    if (m_pend) begin
      if (rvalid) begin
        model_retire(p_rw, p_rd, ref_load(rdata, p_f, p_a));
        m_pend = 0;
      end else begin
        m_valid = 0; m_rw = 0;
      end
    end else if (ex_valid && memread && !rvalid) begin
      m_pend = 1; p_rw = regwrite; p_rd = rd_addr; p_f = width_sel; p_a = alu_result[1:0];
      m_valid = 0; m_rw = 0;
    end else if (ex_valid) begin
      case (wb_sel)
        2'b00:   v = alu_result;
        2'b01:   v = ref_load(rdata, width_sel, alu_result[1:0]);
        2'b10:   v = pc_address + 4;
        default: v = csr_rdata;
      endcase
      model_retire(regwrite, rd_addr, v);
    end else begin
      m_valid = 0; m_rw = 0;
    end
  endtask

  function automatic logic exp_stall();
    if (m_pend) return !rvalid;
    return ex_valid && memread && !rvalid;
  endfunction

  // Called just after a falling edge with inputs already driven; returns at the next falling edge
  task automatic step();
    #1;
    check("stall", stall, exp_stall());
    if (stall) stall_cnt++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("wb_valid", wb_valid, m_valid);
    check("wb_regwrite", wb_regwrite, m_rw);
    if (m_valid) check("wb_rd", wb_rd, m_rd);
    if (m_rw) check("wb_wdata", wb_wdata, m_wdata);
    check("instret", instret, m_inst);
  endtask

  task automatic drive(input logic ev, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f, input logic mr, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] csr, input logic rv, input logic [31:0] rdt);
    ex_valid = ev; regwrite = rw; rd_addr = rd; wb_sel = sel; width_sel = f; memread = mr;
    alu_result = alu; pc_address = pc; csr_rdata = csr; rvalid = rv; rdata = rdt;
  endtask

  task automatic drive_random_alu();
    drive(1'b1, 1'($urandom), 5'($urandom), 2'b00, 3'd0, 1'b0, $urandom, $urandom, $urandom, 1'b0, $urandom);
  endtask

  initial begin
    model_reset();
    // Reset state, with a load-miss pattern driven to prove stall is masked in reset
    drive(1, 1, 5'd3, 2'b01, 3'b010, 1, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_valid", wb_valid, 1'b0);
    check("rst_instret", instret, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ALU op
    drive(1, 1, 5'd5, 2'b00, 3'd0, 0, 32'h0000_1234, 32'h0, 32'h0, 0, 32'h0);
    step();
    check("alu_wdata_const", wb_wdata, 32'h0000_1234);
    check("alu_instret_const", instret, 64'd1);

    // Zero-wait LB and LBU
    drive(1, 1, 5'd7, 2'b01, 3'b000, 1, 32'h0000_0003, 32'h0, 32'h0, 1, 32'h80FF_7F01);
    step();
    check("lb_const", wb_wdata, 32'hFFFF_FF80);
    drive(1, 1, 5'd7, 2'b01, 3'b100, 1, 32'h0000_0003, 32'h0, 32'h0, 1, 32'h80FF_7F01);
    step();
    check("lbu_const", wb_wdata, 32'h0000_0080);

    // Three-cycle-latency LHU; random ex inputs while stalled must be ignored
    stall_cnt = 0;
    drive(1, 1, 5'd9, 2'b01, 3'b101, 1, 32'h0000_0002, 32'h0, 32'h0, 0, 32'h0);
    step();
    repeat (2) begin
      drive_random_alu();
      step();
    end
    drive_random_alu();
    rvalid = 1; rdata = 32'hBEEF_0000;
    step();
    check("lhu_stall_cycles", stall_cnt, 3);
    check("lhu_const", wb_wdata, 32'h0000_BEEF);
    check("lhu_instret", instret, 64'd4);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("lhu_single_pulse", wb_valid, 1'b0);

    // JAL to x0 and x1
    drive(1, 1, 5'd0, 2'b10, 3'd0, 0, 32'h0, 32'h100, 32'h0, 0, 32'h0);
    step();
    check("x0_valid", wb_valid, 1'b1);
    check("x0_regwrite", wb_regwrite, 1'b0);
    drive(1, 1, 5'd1, 2'b10, 3'd0, 0, 32'h0, 32'h100, 32'h0, 0, 32'h0);
    step();
    check("jal_const", wb_wdata, 32'h0000_0104);

    // Stray rvalid in IDLE without a load
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic ld;
      ld = ($urandom_range(0, 99) < 35);
      drive($urandom_range(0, 99) < 75, 1'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            ld ? 2'b01 : 2'($urandom), 3'($urandom), ld, $urandom, $urandom, $urandom,
            1'($urandom), $urandom);
      step();
    end

    // Reset while waiting for a load
    drive(1, 1, 5'd4, 2'b01, 3'b010, 1, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    step();
    if (!m_pend) begin
      // model always goes pending here; this keeps the bench honest if the DUT disagrees
      check("wait_entry", 1'b0, 1'b1);
    end
    check("wait_stall", stall, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_wait_stall", stall, 1'b0);
    check("rst_wait_valid", wb_valid, 1'b0);
    check("rst_wait_regwrite", wb_regwrite, 1'b0);
    check("rst_wait_rd", wb_rd, 5'd0);
    check("rst_wait_wdata", wb_wdata, 32'd0);
    check("rst_wait_instret", instret, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    step();
    check("post_rst_no_wb", wb_valid, 1'b0);
    check("post_rst_instret", instret, 64'd0);

    // Counter wrap
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    m_inst = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1, 1, 5'd2, 2'b11, 3'd0, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 32'h0);
    step();
    check("wrap_const", instret, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
